// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
package arbiter_types;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter sharing one cacheline adaptor port between the I-cache and D-cache.
// One transaction at a time; the granted op/address/wdata are latched and
// held until the adaptor responds, then the owner gets a one-cycle resp.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int FAIR_RR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);

  localparam logic RR_EN = (FAIR_RR != 0);

  arb_state_t        state_reg, state_next;
  grant_t            last_grant_reg, last_grant_next;
  logic              op_write_reg, op_write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic [LINE_W-1:0] line_reg, line_next;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic serve;

  assign i_req = i_pmem_read;
  // A simultaneous read+write from the D-cache is illegal; it is treated as a write.
  assign d_req = d_pmem_read | d_pmem_write;

  // State, grant latch and line capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      op_write_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      line_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      op_write_reg   <= op_write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      line_reg       <= line_next;
    end
  end

  // Arbitration in IDLE, wait for the adaptor in SERVE_x, one-cycle resp in RESP_x.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    op_write_next   = op_write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    line_next       = line_reg;
    grant_d         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          // D wins when alone, under fixed priority, or when I was served last.
          grant_d = d_req && (!i_req || !RR_EN || (last_grant_reg == GRANT_I));
          if (grant_d) begin
            state_next      = SERVE_D;
            last_grant_next = GRANT_D;
            op_write_next   = d_pmem_write;
            addr_next       = d_pmem_address;
            wdata_next      = d_pmem_wdata;
          end else begin
            state_next      = SERVE_I;
            last_grant_next = GRANT_I;
            op_write_next   = 1'b0;
            addr_next       = i_pmem_address;
            wdata_next      = '0;
          end
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          line_next  = pmem_rdata;
          state_next = RESP_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          line_next  = pmem_rdata;
          state_next = RESP_D;
        end
      end
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched grant.
  always_comb begin
    serve        = (state_reg == SERVE_I) || (state_reg == SERVE_D);
    pmem_read    = serve && !op_write_reg;
    pmem_write   = serve && op_write_reg;
    pmem_address = addr_reg;
    pmem_wdata   = wdata_reg;
    i_pmem_rdata = line_reg;
    d_pmem_rdata = line_reg;
    i_pmem_resp  = (state_reg == RESP_I);
    d_pmem_resp  = (state_reg == RESP_D);
    arb_busy     = (state_reg != IDLE);
  end

  a_resp_onehot: assert property (@(posedge clk) !(i_pmem_resp && d_pmem_resp));

  a_no_rw_overlap: assert property (@(posedge clk) !(pmem_read && pmem_write));

  a_serve_stable: assert property (@(posedge clk) disable iff (rst)
    (serve && !pmem_resp) |=> ($stable(pmem_address) && $stable(pmem_wdata) &&
                               $stable(pmem_read) && $stable(pmem_write)));

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: arbitration table plus multi-cycle corner cases.
module tb_cache_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] m_rdata;
  logic         m_resp;

  // round-robin instance
  logic [255:0] ir_data, dr_data, pwd;
  logic         irsp, drsp, pr, pw, busy;
  logic [31:0]  pa;
  // fixed-priority instance
  logic [255:0] ir_data0, dr_data0, pwd0;
  logic         irsp0, drsp0, pr0, pw0, busy0;
  logic [31:0]  pa0;

  int total = 0;
  int bad   = 0;

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .FAIR_RR(1)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(ir_data), .i_pmem_resp(irsp),
    .d_pmem_read(d_read), .d_pmem_write(d_write),
    .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
    .d_pmem_rdata(dr_data), .d_pmem_resp(drsp),
    .pmem_read(pr), .pmem_write(pw), .pmem_address(pa), .pmem_wdata(pwd),
    .pmem_rdata(m_rdata), .pmem_resp(m_resp), .arb_busy(busy)
  );

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .FAIR_RR(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(ir_data0), .i_pmem_resp(irsp0),
    .d_pmem_read(d_read), .d_pmem_write(d_write),
    .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
    .d_pmem_rdata(dr_data0), .d_pmem_resp(drsp0),
    .pmem_read(pr0), .pmem_write(pw0), .pmem_address(pa0), .pmem_wdata(pwd0),
    .pmem_rdata(m_rdata), .pmem_resp(m_resp), .arb_busy(busy0)
  );

  typedef struct {
    logic         ir;
    logic         dr;
    logic         dw;
    logic [31:0]  ia;
    logic [31:0]  da;
    logic [255:0] wd;
    logic         exp_d;
    logic         exp_wr;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_resp  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [255:0] line;
  logic [255:0] last_line;

  initial begin
    // Arbitration table, run from reset (last_grant starts at I).
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h1000, 32'h0,    '0,             1'b0, 1'b0, 32'h1000};
    tv[1] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h2000, '0,             1'b1, 1'b0, 32'h2000};
    tv[2] = '{1'b1, 1'b1, 1'b0, 32'h1100, 32'h2100, '0,             1'b0, 1'b0, 32'h1100};
    tv[3] = '{1'b1, 1'b0, 1'b1, 32'h1200, 32'h2200, {8{32'h5A5A_0003}}, 1'b1, 1'b1, 32'h2200};
    tv[4] = '{1'b1, 1'b1, 1'b0, 32'h1300, 32'h2300, '0,             1'b0, 1'b0, 32'h1300};
    tv[5] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h2400, {8{32'h5A5A_0005}}, 1'b1, 1'b1, 32'h2400};
    tv[6] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h2500, {8{32'h5A5A_0006}}, 1'b1, 1'b1, 32'h2500};
    tv[7] = '{1'b1, 1'b1, 1'b0, 32'h1700, 32'h2700, '0,             1'b0, 1'b0, 32'h1700};

    // Reset state
    do_reset();
    chk("rst_pr", pr, 0);
    chk("rst_pw", pw, 0);
    chk("rst_pa", pa, 0);
    chk("rst_pwd", pwd, 0);
    chk("rst_irsp", irsp, 0);
    chk("rst_drsp", drsp, 0);
    chk("rst_irdata", ir_data, 0);
    chk("rst_drdata", dr_data, 0);
    chk("rst_busy", busy, 0);
    $display("reset state checked");

    // Single I read, adaptor answers on the 5th serve cycle
    i_read = 1'b1;
    i_addr = 32'h0000_0040;
    tick();
    chk("t1_pr", pr, 1);
    chk("t1_pw", pw, 0);
    chk("t1_pa", pa, 32'h40);
    chk("t1_busy", busy, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t1_hold_pr%0d", c), pr, 1);
      chk($sformatf("t1_hold_irsp%0d", c), irsp, 0);
    end
    line    = {8{32'h1111_0040}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t1_irsp", irsp, 1);
    chk("t1_drsp", drsp, 0);
    chk("t1_irdata", ir_data, line);
    chk("t1_pr_drop", pr, 0);
    m_resp = 1'b0;
    i_read = 1'b0;
    tick();
    chk("t1_irsp_end", irsp, 0);
    chk("t1_idle", busy, 0);
    $display("txn I read 0x40 done");

    // Table-driven arbitration
    do_reset();
    for (int k = 0; k < 8; k++) begin
      i_read  = tv[k].ir;
      d_read  = tv[k].dr;
      d_write = tv[k].dw;
      i_addr  = tv[k].ia;
      d_addr  = tv[k].da;
      d_wdata = tv[k].wd;
      tick();
      chk($sformatf("v%0d_pr", k), pr, !tv[k].exp_wr);
      chk($sformatf("v%0d_pw", k), pw, tv[k].exp_wr);
      chk($sformatf("v%0d_pa", k), pa, tv[k].exp_addr);
      if (tv[k].exp_wr) chk($sformatf("v%0d_pwd", k), pwd, tv[k].wd);
      line    = {8{32'hC0DE_0000 + k}};
      m_rdata = line;
      m_resp  = 1'b1;
      tick();
      chk($sformatf("v%0d_irsp", k), irsp, !tv[k].exp_d);
      chk($sformatf("v%0d_drsp", k), drsp, tv[k].exp_d);
      if (!tv[k].exp_wr) begin
        if (tv[k].exp_d) chk($sformatf("v%0d_drdata", k), dr_data, line);
        else             chk($sformatf("v%0d_irdata", k), ir_data, line);
      end
      m_resp  = 1'b0;
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      tick();
      chk($sformatf("v%0d_idle", k), busy, 0);
      $display("vec %0d: owner=%s op=%s addr=%h", k, tv[k].exp_d ? "D" : "I",
               tv[k].exp_wr ? "wr" : "rd", tv[k].exp_addr);
    end

    // Simultaneous I and D reads after reset: D first, then I
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h100;
    d_read = 1'b1;
    d_addr = 32'h200;
    tick();
    chk("t2_first_pa", pa, 32'h200);
    chk("t2_first_pr", pr, 1);
    line    = {8{32'hDDDD_0200}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t2_drsp", drsp, 1);
    chk("t2_irsp_quiet", irsp, 0);
    chk("t2_drdata", dr_data, line);
    m_resp = 1'b0;
    d_read = 1'b0;
    tick();
    chk("t2_gap_idle", busy, 0);
    tick();
    chk("t2_second_pa", pa, 32'h100);
    chk("t2_second_pr", pr, 1);
    line    = {8{32'h1111_0100}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t2_irsp", irsp, 1);
    chk("t2_drsp_quiet", drsp, 0);
    chk("t2_irdata", ir_data, line);
    m_resp = 1'b0;
    i_read = 1'b0;
    tick();
    $display("txn dual read: D 0x200 then I 0x100 done");

    // D writeback held for 10 wait cycles; wdata input changes after grant
    d_write = 1'b1;
    d_addr  = 32'h300;
    d_wdata = {32{8'hA5}};
    tick();
    chk("t3_pw", pw, 1);
    chk("t3_pr", pr, 0);
    d_wdata = '0;
    d_addr  = 32'hFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t3_pwd%0d", c), pwd, {32{8'hA5}});
      chk($sformatf("t3_pa%0d", c), pa, 32'h300);
      chk($sformatf("t3_pw%0d", c), pw, 1);
      chk($sformatf("t3_drsp%0d", c), drsp, 0);
    end
    last_line = {8{32'h3333_0300}};
    m_rdata   = last_line;
    m_resp    = 1'b1;
    tick();
    chk("t3_drsp", drsp, 1);
    chk("t3_irsp", irsp, 0);
    chk("t3_pw_drop", pw, 0);
    m_resp  = 1'b0;
    d_write = 1'b0;
    tick();
    chk("t3_drsp_single", drsp, 0);
    $display("txn D write 0x300 done");

    // Spurious adaptor resp in IDLE, then I address change during SERVE_I
    m_rdata = {8{32'hBAD0_BAD0}};
    m_resp  = 1'b1;
    tick();
    chk("t6_spur_irsp", irsp, 0);
    chk("t6_spur_drsp", drsp, 0);
    chk("t6_spur_busy", busy, 0);
    m_resp = 1'b0;
    tick();
    chk("t6_spur_irsp2", irsp, 0);
    chk("t6_spur_line", ir_data, last_line);
    i_read = 1'b1;
    i_addr = 32'h800;
    tick();
    chk("t6_pa", pa, 32'h800);
    i_addr = 32'h900;
    tick();
    tick();
    chk("t6_pa_held", pa, 32'h800);
    line    = {8{32'h6666_0800}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t6_irsp", irsp, 1);
    chk("t6_irdata", ir_data, line);
    m_resp = 1'b0;
    i_read = 1'b0;
    tick();
    $display("txn spurious resp + I read 0x800 done");

    // Reset in the middle of SERVE_D
    d_read = 1'b1;
    d_addr = 32'h600;
    tick();
    chk("t5_pr", pr, 1);
    chk("t5_pa", pa, 32'h600);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_pr", pr, 0);
    chk("t5_rst_pa", pa, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_irdata", ir_data, 0);
    chk("t5_rst_drsp", drsp, 0);
    rst    = 1'b0;
    d_read = 1'b0;
    i_read = 1'b1;
    i_addr = 32'h700;
    tick();
    chk("t5_new_pa", pa, 32'h700);
    chk("t5_new_pr", pr, 1);
    line    = {8{32'h5555_0700}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t5_irsp", irsp, 1);
    chk("t5_irdata", ir_data, line);
    m_resp = 1'b0;
    i_read = 1'b0;
    tick();
    $display("txn reset mid SERVE_D + I read 0x700 done");

    // Fixed priority (FAIR_RR=0): D back-to-back, I waits, then I served
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h400;
    d_read = 1'b1;
    d_addr = 32'h500;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("t4_r%0d_pa", r), pa0, 32'h500 + 32'h20 * r);
      chk($sformatf("t4_r%0d_pr", r), pr0, 1);
      m_rdata = {8{32'h4444_0000 + r}};
      m_resp  = 1'b1;
      tick();
      chk($sformatf("t4_r%0d_drsp", r), drsp0, 1);
      chk($sformatf("t4_r%0d_irsp", r), irsp0, 0);
      m_resp = 1'b0;
      d_addr = 32'h500 + 32'h20 * (r + 1);
      if (r == 2) d_read = 1'b0;
      tick();
      chk($sformatf("t4_r%0d_idle", r), busy0, 0);
    end
    tick();
    chk("t4_i_pa", pa0, 32'h400);
    chk("t4_i_pr", pr0, 1);
    line    = {8{32'h4444_0400}};
    m_rdata = line;
    m_resp  = 1'b1;
    tick();
    chk("t4_irsp", irsp0, 1);
    chk("t4_drsp", drsp0, 0);
    chk("t4_irdata", ir_data0, line);
    m_resp = 1'b0;
    i_read = 1'b0;
    tick();
    $display("txn fixed priority: 3x D then I 0x400 done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
